// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM encoding,
// prefix bytes, set-2 scan codes and the direction bytes sent to the
// movement controller. Macro PS2_WASD_EN adds the W/A/S/D keys to the map.
package ps2_pkg;

  typedef enum logic [1:0] {
    FR_IDLE   = 2'd0,
    FR_DATA   = 2'd1,
    FR_PARITY = 2'd2,
    FR_STOP   = 2'd3
  } frame_state_t;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;

  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_RIGHT  = 8'h74;

  localparam logic [7:0] SC_W      = 8'h1D;
  localparam logic [7:0] SC_A      = 8'h1C;
  localparam logic [7:0] SC_S      = 8'h1B;
  localparam logic [7:0] SC_D      = 8'h23;

  localparam logic [7:0] DIR_UP    = 8'h48;
  localparam logic [7:0] DIR_LEFT  = 8'h4B;
  localparam logic [7:0] DIR_DOWN  = 8'h50;
  localparam logic [7:0] DIR_RIGHT = 8'h4D;

  typedef struct packed {
    logic       hit;
    logic [7:0] dir;
  } dir_map_t;

  // Translate a make code to a direction byte; hit=0 for unmapped codes.
  function automatic dir_map_t map_code(input logic ext, input logic [7:0] code);
    dir_map_t m;
    m.hit = 1'b0;
    m.dir = 8'h00;
    if (ext) begin
      case (code)
        SC_UP:    begin m.hit = 1'b1; m.dir = DIR_UP;    end
        SC_LEFT:  begin m.hit = 1'b1; m.dir = DIR_LEFT;  end
        SC_DOWN:  begin m.hit = 1'b1; m.dir = DIR_DOWN;  end
        SC_RIGHT: begin m.hit = 1'b1; m.dir = DIR_RIGHT; end
        default:  m.hit = 1'b0;
      endcase
    end
`ifdef PS2_WASD_EN
    else begin
      case (code)
        SC_W:    begin m.hit = 1'b1; m.dir = DIR_UP;    end
        SC_A:    begin m.hit = 1'b1; m.dir = DIR_LEFT;  end
        SC_S:    begin m.hit = 1'b1; m.dir = DIR_DOWN;  end
        SC_D:    begin m.hit = 1'b1; m.dir = DIR_RIGHT; end
        default: m.hit = 1'b0;
      endcase
    end
`endif
    return m;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises and filters the keyboard lines, samples
// data on each falling edge of the filtered clock, assembles 11-bit frames
// and abandons a frame that stalls for TIMEOUT cycles.
//
// Output handshake: rx_valid is a one-cycle qualifier for rx_byte; there is
// no backpressure, the consumer must take the byte in that cycle.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILT_LEN = 4,
  parameter int TIMEOUT  = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int FILT_W = $clog2(FILT_LEN + 1);
  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_LEN - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);

  logic clk_s1, clk_s2, dat_s1, dat_s2;
  logic clk_filt;
  logic [FILT_W-1:0] filt_cnt;
  logic tick;

  frame_state_t state, state_nxt;
  logic [2:0]      bit_cnt, bit_cnt_nxt;
  logic [7:0]      shift, shift_nxt;
  logic            par_ok, par_ok_nxt;
  logic [WD_W-1:0] wd_cnt, wd_nxt;
  logic            valid_nxt, err_nxt;

  // Two-flop synchronisers; idle bus level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Accept a clock level change only after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_LAST) begin
      clk_filt <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FILT_W'(1);
    end
  end

  // Sample tick: the cycle on which the filtered clock falls.
  assign tick = clk_filt & ~clk_s2 & (filt_cnt == FILT_LAST);

  // Frame FSM and watchdog state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FR_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par_ok    <= 1'b0;
      wd_cnt    <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_byte   <= '0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift     <= shift_nxt;
      par_ok    <= par_ok_nxt;
      wd_cnt    <= wd_nxt;
      rx_valid  <= valid_nxt;
      frame_err <= err_nxt;
      if (valid_nxt) rx_byte <= shift;
    end
  end

  // Next-state logic: one transition per tick, watchdog restarts on each tick.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    par_ok_nxt  = par_ok;
    wd_nxt      = wd_cnt;
    valid_nxt   = 1'b0;
    err_nxt     = 1'b0;

    if (state == FR_IDLE || tick) begin
      wd_nxt = '0;
    end else if (wd_cnt == WD_LAST) begin
      wd_nxt    = '0;
      state_nxt = FR_IDLE;
      err_nxt   = 1'b1;
    end else begin
      wd_nxt = wd_cnt + WD_W'(1);
    end

    if (tick) begin
      case (state)
        FR_IDLE: begin
          if (!dat_s2) begin
            state_nxt   = FR_DATA;
            bit_cnt_nxt = '0;
          end
        end
        FR_DATA: begin
          shift_nxt   = {dat_s2, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = FR_PARITY;
        end
        FR_PARITY: begin
          par_ok_nxt = ^{shift, dat_s2};
          state_nxt  = FR_STOP;
        end
        FR_STOP: begin
          if (dat_s2 && par_ok) valid_nxt = 1'b1;
          else                  err_nxt   = 1'b1;
          state_nxt = FR_IDLE;
        end
        default: state_nxt = FR_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard front end for the pacman movement controller. Tracks the
// E0/F0 prefixes, maps arrow make codes (plus W/A/S/D when PS2_WASD_EN is
// defined) to direction bytes and emits each as a STATE_HOLD-cycle strobe,
// holding at most one pending event while a strobe is in progress.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILT_LEN   = 4,
  parameter int STATE_HOLD = 16,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ps2_byte,
  output logic       ps2_state,
  output logic       frame_err
);

  localparam int HOLD_W = $clog2(STATE_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STATE_HOLD - 1);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       ext, brk, ext_nxt, brk_nxt;
  logic       ev_valid;
  logic [7:0] ev_code;
  dir_map_t   map_res;
  logic       pend_valid;
  logic [7:0] pend_code;
  logic [HOLD_W-1:0] hold_cnt;

  ps2_frame_rx #(
    .FILT_LEN (FILT_LEN),
    .TIMEOUT  (TIMEOUT)
  ) u_frame (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  // Prefix tracking and code map; a release (brk set) never produces an event.
  always_comb begin
    ext_nxt  = ext;
    brk_nxt  = brk;
    ev_valid = 1'b0;
    ev_code  = 8'h00;
    map_res  = map_code(ext, rx_byte);
    if (rx_valid) begin
      if (rx_byte == PFX_EXT) begin
        ext_nxt = 1'b1;
      end else if (rx_byte == PFX_BRK) begin
        brk_nxt = 1'b1;
      end else begin
        ext_nxt = 1'b0;
        brk_nxt = 1'b0;
        if (!brk && map_res.hit) begin
          ev_valid = 1'b1;
          ev_code  = map_res.dir;
        end
      end
    end
  end

  // Prefix flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else begin
      ext <= ext_nxt;
      brk <= brk_nxt;
    end
  end

  // Strobe timer and one-deep pending slot; a low ps2_state cycle always
  // precedes a rise because a new strobe only starts from the low state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps2_byte   <= 8'h00;
      ps2_state  <= 1'b0;
      hold_cnt   <= '0;
      pend_valid <= 1'b0;
      pend_code  <= 8'h00;
    end else if (ps2_state) begin
      if (hold_cnt == HOLD_LAST) begin
        ps2_state <= 1'b0;
        hold_cnt  <= '0;
      end else begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
      if (ev_valid) begin
        pend_valid <= 1'b1;
        pend_code  <= ev_code;
      end
    end else if (ev_valid) begin
      ps2_state  <= 1'b1;
      ps2_byte   <= ev_code;
      hold_cnt   <= '0;
      pend_valid <= 1'b0;
    end else if (pend_valid) begin
      ps2_state  <= 1'b1;
      ps2_byte   <= pend_code;
      hold_cnt   <= '0;
      pend_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx. Instance 0 uses the default parameters; instance
// 1 uses short frames and a long strobe so decodes land while ps2_state is high.
// Build with +define+PS2_WASD_EN to cover the W/A/S/D map.
module tb_ps2_keyboard_rx;

  localparam int HOLD0 = 16;
  localparam int HOLD1 = 450;
  localparam int HP0   = 8;
  localparam int HP1   = 4;
  localparam int TO0   = 50000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk0 = 1'b1, ps2_data0 = 1'b1;
  logic ps2_clk1 = 1'b1, ps2_data1 = 1'b1;
  logic [7:0] byte0, byte1;
  logic state0, state1, err0, err1;

  // Clock generation.
  always #5 clk = ~clk;

  ps2_keyboard_rx dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk0),
    .ps2_data  (ps2_data0),
    .ps2_byte  (byte0),
    .ps2_state (state0),
    .frame_err (err0)
  );

  ps2_keyboard_rx #(.FILT_LEN(1), .STATE_HOLD(HOLD1), .TIMEOUT(1000)) dut_fast (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk1),
    .ps2_data  (ps2_data1),
    .ps2_byte  (byte1),
    .ps2_state (state1),
    .frame_err (err1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int err_cnt[2]  = '{0, 0};
  int ev_cnt[2]   = '{0, 0};
  int push_cnt[2] = '{0, 0};
  int last_gap[2] = '{0, 0};
  logic [7:0] last_exp[2] = '{8'h00, 8'h00};
  int exp_err0 = 0;

  logic [7:0] arrow_sc[4] = '{8'h75, 8'h6B, 8'h72, 8'h74};
  logic [7:0] wasd_sc[4]  = '{8'h1D, 8'h1C, 8'h1B, 8'h23};
  logic [7:0] dir_code[4] = '{8'h48, 8'h4B, 8'h50, 8'h4D};
  logic m_ext[2] = '{1'b0, 1'b0};
  logic m_brk[2] = '{1'b0, 1'b0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference model: keyboard prefix rules applied byte by byte.
  task automatic model_byte(input int i, input logic [7:0] b, output int code);
    code = -1;
    if (b == 8'hE0) m_ext[i] = 1'b1;
    else if (b == 8'hF0) m_brk[i] = 1'b1;
    else begin
      if (!m_brk[i]) begin
        for (int k = 0; k < 4; k++) begin
          if (m_ext[i] && b == arrow_sc[k]) code = int'(dir_code[k]);
`ifdef PS2_WASD_EN
          if (!m_ext[i] && b == wasd_sc[k]) code = int'(dir_code[k]);
`endif
        end
      end
      m_ext[i] = 1'b0;
      m_brk[i] = 1'b0;
    end
  endtask

  task automatic set_lines(input int i, input logic c, input logic d);
    if (i == 0) begin ps2_clk0 = c; ps2_data0 = d; end
    else        begin ps2_clk1 = c; ps2_data1 = d; end
  endtask

  task automatic send_bit(input int i, input logic b);
    int hp;
    hp = (i == 0) ? HP0 : HP1;
    set_lines(i, 1'b1, b);
    repeat (hp / 2) @(negedge clk);
    set_lines(i, 1'b0, b);
    repeat (hp) @(negedge clk);
    set_lines(i, 1'b1, b);
    repeat (hp / 2) @(negedge clk);
  endtask

  task automatic send_frame(input int i, input logic [7:0] b, input logic bad_par);
    send_bit(i, 1'b0);
    for (int k = 0; k < 8; k++) send_bit(i, b[k]);
    send_bit(i, ~(^b) ^ bad_par);
    send_bit(i, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  // Valid frame; the expected event (if any) is queued before the frame starts.
  task automatic send_key(input int i, input logic [7:0] b, input bit push_en);
    int code;
    model_byte(i, b, code);
    if (code >= 0 && push_en) begin
      if (i == 0) exp_q0.push_back(8'(code));
      else        exp_q1.push_back(8'(code));
      push_cnt[i]++;
      last_exp[i] = 8'(code);
    end
    send_frame(i, b, 1'b0);
  endtask

  // Monitor: pops on each strobe rise, checks strobe width, counts errors.
  logic       mon_prev[2] = '{1'b0, 1'b0};
  int         hi_len[2]   = '{0, 0};
  int         lo_len[2]   = '{1000, 1000};
  logic [7:0] cur_byte[2] = '{8'h00, 8'h00};
  always @(negedge clk) begin : monitor
    logic       st_v, er_v, have;
    logic [7:0] by_v, exp_v;
    for (int i = 0; i < 2; i++) begin
      st_v = (i == 0) ? state0 : state1;
      er_v = (i == 0) ? err0   : err1;
      by_v = (i == 0) ? byte0  : byte1;
      if (rst) begin
        mon_prev[i] = 1'b0;
        hi_len[i]   = 0;
        lo_len[i]   = 1000;
      end else begin
        if (er_v) err_cnt[i]++;
        if (st_v && !mon_prev[i]) begin
          last_gap[i] = lo_len[i];
          ev_cnt[i]++;
          exp_v = 8'h00;
          if (i == 0) begin have = (exp_q0.size() != 0); if (have) exp_v = exp_q0.pop_front(); end
          else        begin have = (exp_q1.size() != 0); if (have) exp_v = exp_q1.pop_front(); end
          if (!have) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event[%0d]: got %0h required none", i, by_v);
          end else begin
            check($sformatf("event_byte[%0d]", i), by_v, exp_v);
          end
          hi_len[i]   = 1;
          cur_byte[i] = by_v;
        end else if (st_v) begin
          hi_len[i]++;
        end else if (mon_prev[i]) begin
          check($sformatf("strobe_len[%0d]", i), hi_len[i], (i == 0) ? HOLD0 : HOLD1);
          check($sformatf("byte_hold[%0d]", i), by_v, cur_byte[i]);
          lo_len[i] = 1;
        end else begin
          lo_len[i]++;
        end
        mon_prev[i] = st_v;
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    int e0, v0;
    logic [7:0] pfx;
    pfx = 8'hE0;

    repeat (5) @(negedge clk);
    check("rst_byte0", byte0, 8'h00);
    check("rst_state0", state0, 1'b0);
    check("rst_err0", err0, 1'b0);
    check("rst_byte1", byte1, 8'h00);
    check("rst_state1", state1, 1'b0);
    check("rst_err1", err1, 1'b0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Extended up arrow.
    e0 = err_cnt[0];
    send_key(0, 8'hE0, 1);
    send_key(0, 8'h75, 1);
    repeat (40) @(negedge clk);
    check("up_events", ev_cnt[0], push_cnt[0]);
    check("up_no_err", err_cnt[0], e0);

    // Release: no event, byte unchanged.
    send_key(0, 8'hE0, 1);
    send_key(0, 8'hF0, 1);
    send_key(0, 8'h75, 1);
    repeat (40) @(negedge clk);
    check("release_events", ev_cnt[0], push_cnt[0]);
    check("release_byte", byte0, last_exp[0]);

    // Parity error then a good right arrow.
    e0 = err_cnt[0];
    send_frame(0, 8'h6B, 1'b1);
    exp_err0++;
    repeat (40) @(negedge clk);
    check("parity_err", err_cnt[0], e0 + 1);
    check("parity_events", ev_cnt[0], push_cnt[0]);
    send_key(0, 8'hE0, 1);
    send_key(0, 8'h74, 1);
    repeat (40) @(negedge clk);
    check("right_events", ev_cnt[0], push_cnt[0]);

    // Glitch mid-frame, then a stall after 4 data bits.
    e0 = err_cnt[0];
    send_bit(0, 1'b0);
    send_bit(0, pfx[0]);
    send_bit(0, pfx[1]);
    @(negedge clk);
    ps2_clk0 = 1'b0;
    #2;
    ps2_clk0 = 1'b1;
    send_bit(0, pfx[2]);
    send_bit(0, pfx[3]);
    repeat (TO0 + 100) @(negedge clk);
    check("timeout_err", err_cnt[0], e0 + 1);
    exp_err0++;
    send_key(0, 8'hE0, 1);
    send_key(0, 8'h72, 1);
    repeat (40) @(negedge clk);
    check("down_events", ev_cnt[0], push_cnt[0]);

    // Randomised key traffic.
    for (int n = 0; n < 30; n++) begin
      int kind, k;
      logic [7:0] rb;
      kind = $urandom_range(0, 5);
      k    = $urandom_range(0, 3);
      rb   = 8'($urandom_range(0, 255));
      case (kind)
        0, 1: begin send_key(0, 8'hE0, 1); send_key(0, arrow_sc[k], 1); end
        2:    begin send_key(0, 8'hE0, 1); send_key(0, 8'hF0, 1); send_key(0, arrow_sc[k], 1); end
        3:    send_key(0, wasd_sc[k], 1);
        4:    begin
                if ($urandom_range(0, 1) == 1) send_key(0, 8'hF0, 1);
                send_key(0, rb, 1);
              end
        default: begin send_frame(0, rb, 1'b1); exp_err0++; end
      endcase
    end
    repeat (40) @(negedge clk);
    check("random_events", ev_cnt[0], push_cnt[0]);
    check("random_errs", err_cnt[0], exp_err0);

    // Pending slot: one event arriving while the strobe is high.
    send_key(1, 8'hE0, 1);
    send_key(1, 8'h75, 1);
    send_key(1, 8'hE0, 1);
    send_key(1, 8'h6B, 1);
    repeat (1000) @(negedge clk);
    check("pend_events", ev_cnt[1], push_cnt[1]);
    check("pend_gap", last_gap[1], 1);

    // Pending slot overwrite: the middle event is replaced by the newest.
    send_key(1, 8'hE0, 1);
    send_key(1, 8'h75, 1);
    send_key(1, 8'hE0, 1);
    send_key(1, 8'h6B, 0);
    send_key(1, 8'hE0, 1);
    send_key(1, 8'h72, 1);
    repeat (1000) @(negedge clk);
    check("overwrite_events", ev_cnt[1], push_cnt[1]);
    check("overwrite_gap", last_gap[1], 1);

    // Reset after the start bit of E0; rest of the frame sent during reset.
    send_bit(0, 1'b0);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) send_bit(0, pfx[k]);
    send_bit(0, ~(^pfx));
    send_bit(0, 1'b1);
    check("midrst_byte0", byte0, 8'h00);
    check("midrst_state0", state0, 1'b0);
    check("midrst_err0", err0, 1'b0);
    check("midrst_byte1", byte1, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin m_ext[i] = 1'b0; m_brk[i] = 1'b0; end
    repeat (20) @(negedge clk);
    v0 = err_cnt[0];
    send_key(0, 8'h1D, 1);
    repeat (40) @(negedge clk);
    check("bare_1d_events", ev_cnt[0], push_cnt[0]);
    check("post_rst_no_err", err_cnt[0], v0);

    check("q0_empty", exp_q0.size(), 0);
    check("q1_empty", exp_q1.size(), 0);
    check("total_errs0", err_cnt[0], exp_err0);
    check("total_errs1", err_cnt[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
